// File: rtl/slt_multicycle_pkg.sv
// slt_multicycle_pkg: shared state encoding and parameter legality helper for the multi-cycle SLT unit.
package slt_multicycle_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic bit chunk_legal(input int width, input int chunk);
        return chunk >= 1 && chunk <= width && width % chunk == 0;
    endfunction
endpackage

// File: rtl/slt_chunk_sub.sv
// slt_chunk_sub: combinational CHUNK-bit slice of a + ~b + cin, exposing the carry into the slice MSB.
module slt_chunk_sub import slt_multicycle_pkg::*; #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y_inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y_inv} + (CHUNK + 1)'(cin);
    // The carry into the MSB is recovered from the MSB sum bit, so CHUNK = 1 needs no special case.
    assign cmsb = sum[CHUNK-1] ^ x[CHUNK-1] ^ y_inv[CHUNK-1];
endmodule

// File: rtl/slt_multicycle.sv
// slt_multicycle: set-less-than built from a CHUNK-bit subtract slice iterated LSB-first,
// with valid/ready handshakes on both sides.
module slt_multicycle import slt_multicycle_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("slt_multicycle: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b_inv, r_acc, r_diff, r_result, w_acc;
    logic [KW-1:0]    r_k;
    logic             r_c, r_sm, r_zacc, r_cout, r_ovf, r_zero;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout, w_cmsb, w_last, w_ovf, w_lt, w_zacc;

    assign w_base = 32'(r_k) * CHUNK;

    slt_chunk_sub #(.CHUNK(CHUNK)) u_sub (
        .x     (r_a[w_base +: CHUNK]),
        .y_inv (r_b_inv[w_base +: CHUNK]),
        .cin   (r_c),
        .sum   (w_sum),
        .cout  (w_cout),
        .cmsb  (w_cmsb)
    );

    assign w_last = r_k == KW'(NCHUNK - 1);
    assign w_ovf  = w_cmsb ^ w_cout;
    assign w_zacc = r_zacc & ~|w_sum;
    // On the last slice, the slice MSB is the MSB of the full difference.
    assign w_lt   = r_sm ? w_sum[CHUNK-1] ^ w_ovf : ~w_cout;

    always_comb begin
        w_acc = r_acc;
        w_acc[w_base +: CHUNK] = w_sum;
    end

    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    always_comb begin
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        w_next    = r_state == IDLE ? (in_valid ? RUN : IDLE)
                  : r_state == RUN  ? (w_last ? DONE : RUN)
                  : (out_ready ? IDLE : DONE);
    end

    // Visible results load only on DONE entry, so they hold through IDLE and the next RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_diff   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_acc    <= '0;
            r_k      <= '0;
            r_c      <= 1'b0;
            r_zacc   <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a     <= a;
            r_b_inv <= ~b;
            r_sm    <= signed_mode;
            r_c     <= 1'b1;
            r_k     <= '0;
            r_acc   <= '0;
            r_zacc  <= 1'b1;
        end else if (r_state == RUN) begin
            r_acc  <= w_acc;
            r_c    <= w_cout;
            r_zacc <= w_zacc;
            r_k    <= r_k + 1'b1;
            if (w_last) begin
                r_diff   <= w_acc;
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
                r_zero   <= w_zacc;
                r_result <= WIDTH'(w_lt);
            end
        end
    end

    assign result   = r_result;
    assign diff     = r_diff;
    assign carryout = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;
endmodule
